// File: rtl/instr_mem_loader_if.sv
// Loader bus: control/status, byte stream handshake and instruction-memory write port.
// master drives start/count/stream and observes the rest; slave is the loader.
interface instr_mem_loader_if;
    logic        start_i;
    logic [5:0]  word_count_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        busy_o;
    logic        done_o;
    logic        cpu_rst_o;
    logic [31:0] checksum_o;

    modport master (
        output start_i, word_count_i, byte_valid_i, byte_data_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
               busy_o, done_o, cpu_rst_o, checksum_o
    );

    modport slave (
        input  start_i, word_count_i, byte_valid_i, byte_data_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
               busy_o, done_o, cpu_rst_o, checksum_o
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Program loader: packs a byte stream MSB-first into 32-bit words, writes them to
// instruction memory and holds the CPU in reset until the requested load completes.
module instr_mem_loader #(
    parameter int          WORDS     = 32,
    parameter logic [31:0] ADDR_BASE = 32'd0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    instr_mem_loader_if.slave bus
);
    localparam int IW = $clog2(WORDS) + 1;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t        state_q;
    logic [IW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_nxt;
    logic [IW-1:0] start_cnt;
    logic [1:0]    bcnt_q;
    logic [31:0]   word_q;
    logic [31:0]   word_shift;
    logic          xfer;
    logic          byte_ready_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_data_q;
    logic          busy_q;
    logic          done_q;
    logic          cpu_rst_q;
    logic [31:0]   checksum_q;

    // Requests beyond the memory depth are clamped rather than wrapping the index.
    assign start_cnt  = (32'(bus.word_count_i) > 32'(WORDS)) ? IW'(WORDS) : IW'(bus.word_count_i);
    assign idx_nxt    = idx_q + IW'(1);
    assign xfer       = bus.byte_valid_i & byte_ready_q;
    assign word_shift = {word_q[23:0], bus.byte_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_rst_q    <= 1'b1;
            checksum_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        cnt_q      <= start_cnt;
                        idx_q      <= '0;
                        bcnt_q     <= '0;
                        checksum_q <= '0;
                        if (start_cnt == '0) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q      <= RECV;
                            done_q       <= 1'b0;
                            busy_q       <= 1'b1;
                            cpu_rst_q    <= 1'b1;
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (xfer) begin
                        word_q <= word_shift;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            state_q      <= WRITE;
                            byte_ready_q <= 1'b0;
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= ADDR_BASE + 32'({idx_q, 2'b00});
                            mem_data_q   <= word_shift;
                        end
                    end
                end
                WRITE: begin
                    mem_we_q   <= 1'b0;
                    checksum_q <= checksum_q + word_q;
                    idx_q      <= idx_nxt;
                    bcnt_q     <= '0;
                    if (idx_nxt == cnt_q) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        state_q      <= RECV;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready_o = byte_ready_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.cpu_rst_o    = cpu_rst_q;
    assign bus.checksum_o   = checksum_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed and randomized loads checked against a
// word-level reference model (byte packing, address list, checksum, completion time).
module tb_instr_mem_loader;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [7:0]  bytes_q[$];
    logic [63:0] wr_q[$];

    instr_mem_loader_if bus ();

    instr_mem_loader dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write strobe seen mid-cycle is logged as {addr, data}.
    always @(negedge clk) begin
        if (bus.mem_we_o === 1'b1) wr_q.push_back({bus.mem_addr_o, bus.mem_data_o});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        bytes_q.push_back(w[31:24]);
        bytes_q.push_back(w[23:16]);
        bytes_q.push_back(w[15:8]);
        bytes_q.push_back(w[7:0]);
    endtask

    task automatic fill_random(input int nbytes);
        for (int i = 0; i < nbytes; i++) bytes_q.push_back(8'($urandom));
    endtask

    // Starts a load of cnt words, streams bytes_q (optionally every other cycle)
    // and checks the memory writes, checksum and status against the model.
    task automatic run_load(input int cnt, input bit gapped);
        int          n;
        int          base;
        int          supplied;
        int          sc;
        int          guard;
        bit          tgl;
        bit          v;
        logic [31:0] sum;
        logic [31:0] exp_data[$];

        n        = (cnt > 32) ? 32 : cnt;
        supplied = bytes_q.size();
        sum      = '0;
        for (int i = 0; i < n; i++) begin
            exp_data.push_back({bytes_q[4*i], bytes_q[4*i+1], bytes_q[4*i+2], bytes_q[4*i+3]});
            sum = sum + exp_data[i];
        end
        base = wr_q.size();

        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.word_count_i = 6'(cnt);
        @(negedge clk);
        bus.start_i = 1'b0;
        sc          = cyc;
        chk("start_checksum_clear", 64'(bus.checksum_o), 64'(0));
        chk("start_busy", 64'(bus.busy_o), 64'(n > 0));
        chk("start_cpu_rst", 64'(bus.cpu_rst_o), 64'(n > 0));
        chk("start_done", 64'(bus.done_o), 64'(n == 0));

        tgl   = 1'b1;
        guard = 0;
        while (bus.done_o !== 1'b1 && guard < 2000) begin
            v = (bytes_q.size() > 0) && (!gapped || tgl);
            tgl = ~tgl;
            bus.byte_valid_i = v;
            bus.byte_data_i  = v ? bytes_q[0] : 8'($urandom);
            if (v && bus.byte_ready_o === 1'b1) void'(bytes_q.pop_front());
            @(negedge clk);
            guard++;
        end
        bus.byte_valid_i = 1'b0;

        chk("load_timeout", 64'(guard >= 2000), 64'(0));
        if (!gapped) chk("done_latency", 64'(cyc - sc), 64'(5 * n));
        chk("write_count", 64'(wr_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < wr_q.size())
                chk("write_addr_data", wr_q[base+i], {32'(4 * i), exp_data[i]});
        end
        chk("bytes_consumed", 64'(supplied - bytes_q.size()), 64'(4 * n));
        chk("checksum", 64'(bus.checksum_o), 64'(sum));
        chk("done_cpu_rst", 64'(bus.cpu_rst_o), 64'(0));
        chk("done_busy", 64'(bus.busy_o), 64'(0));
        chk("done_ready", 64'(bus.byte_ready_o), 64'(0));
        bytes_q.delete();
    endtask

    initial begin
        int base;

        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.word_count_i = '0;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = '0;

        // Reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_cpu_rst", 64'(bus.cpu_rst_o), 64'(1));
        chk("rst_done", 64'(bus.done_o), 64'(0));
        chk("rst_ready", 64'(bus.byte_ready_o), 64'(0));
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_addr", 64'(bus.mem_addr_o), 64'(0));
        chk("rst_data", 64'(bus.mem_data_o), 64'(0));
        chk("rst_checksum", 64'(bus.checksum_o), 64'(0));
        repeat (10) @(negedge clk);
        chk("idle_no_writes", 64'(wr_q.size()), 64'(0));
        chk("idle_cpu_rst", 64'(bus.cpu_rst_o), 64'(1));

        // Two words, continuous valid
        push_word(32'h8C010004);
        push_word(32'h20420001);
        run_load(2, 1'b0);
        chk("two_word_checksum", 64'(bus.checksum_o), 64'h0000_0000_AC43_0005);

        // Gapped valid
        push_word(32'h12345678);
        run_load(1, 1'b1);

        // Count boundaries
        run_load(0, 1'b0);
        fill_random(160);
        run_load(40, 1'b0);
        chk("last_addr", 64'(wr_q[wr_q.size()-1][63:32]), 64'(124));

        // Reset mid-word
        base = wr_q.size();
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.word_count_i = 6'd1;
        @(negedge clk);
        bus.start_i      = 1'b0;
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = 8'h11;
        @(negedge clk);
        bus.byte_data_i  = 8'h22;
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        rst              = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 64'(bus.byte_ready_o), 64'(0));
        chk("midrst_busy", 64'(bus.busy_o), 64'(0));
        chk("midrst_cpu_rst", 64'(bus.cpu_rst_o), 64'(1));
        chk("midrst_checksum", 64'(bus.checksum_o), 64'(0));
        chk("midrst_data", 64'(bus.mem_data_o), 64'(0));
        chk("midrst_no_write", 64'(wr_q.size() - base), 64'(0));
        push_word(32'hAABBCCDD);
        run_load(1, 1'b0);

        // Restart from DONE (checksum is nonzero going in)
        fill_random(4);
        run_load(1, 1'b0);

        // Randomized loads
        for (int k = 0; k < 8; k++) begin
            int cnt;
            cnt = int'($urandom_range(1, 6));
            fill_random(4 * cnt + int'($urandom_range(0, 3)));
            run_load(cnt, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
